mem_port_arbiter_4ch: RTL
=========================

// Module: mem_port_arbiter_4ch
// PURPOSE
//  Round-robin arbiter and sequencer that shares one 32-bit memory port among four requesters
//  (e.g. IF, MEM, debug, DMA). Grants one requester per transaction and drives the 2-bit select
//  of the 32-bit 4:1 payload muxes (addr, wdata) that feed the shared port. Runs each access to
//  completion and returns read data plus a done pulse to the winner.
// PARAMETERS
//  AW       32  address width per requester
//  TIMEOUT  16  max ACCESS cycles without mem_ready before abort (ARB_TIMEOUT_EN only); >=2
// PORTS
//  CLK        in   1     clock, all state updates on rising edge
//  RESETN     in   1     reset, synchronous, active-low
//  req        in   4     per-requester request, held until its done pulse
//  req_we     in   4     per-requester write enable (1=write)
//  req_addr   in   4*AW  packed addresses, requester i at [i*AW +: AW]
//  req_wdata  in   128   packed write data, requester i at [i*32 +: 32]
//  grant      out  4     one-hot current owner, 0 when idle
//  done       out  4     one-hot 1-cycle completion pulse
//  rdata      out  32    read data latched at completion, valid while done!=0
//  sel        out  2     select for the 4:1 payload muxes (index of owner)
//  mem_req    out  1     access strobe to shared port
//  mem_we     out  1     write enable of owner
//  mem_addr   out  AW    owner address (via mux_32b_4to1-style selection on sel)
//  mem_wdata  out  32    owner write data
//  mem_ready  in   1     port completes access this cycle
//  mem_rdata  in   32    port read data, valid with mem_ready
//  busy       out  1     1 in ACCESS or DONE
//  err        out  1     1-cycle timeout pulse, concurrent with done (0 without ARB_TIMEOUT_EN)
// BEHAVIOUR
//  Reset (RESETN=0 at edge): state=IDLE, last=2'd3, grant=0, sel=0, done=0, rdata=0,
//   mem_req=0, busy=0, err=0, timeout count=0. Reset mid-access aborts it; no done is issued.
//  FSM states IDLE, ACCESS, DONE:
//   IDLE:   req sampled; if any set, winner = first set bit scanning last+1, last+2, ... mod 4;
//           next edge: grant=onehot(winner), sel=winner, last=winner, -> ACCESS. Else stay.
//   ACCESS: mem_req=1; mem_we/addr/wdata = owner's, sel stable. If mem_ready: rdata<=mem_rdata,
//           done<=grant, -> DONE. Else stay.
//   DONE:   done pulse visible this cycle, mem_req=0, grant held; next edge: grant=0, done=0,
//           -> IDLE. sel keeps last winner in IDLE.
//  Latency: req in IDLE cycle n -> mem_req cycle n+1 -> done cycle n+2 if mem_ready at n+1.
//   Minimum 3 cycles/transaction; back-to-back requests alternate fairly.
//  Requests are sampled only in IDLE; dropping req during ACCESS does not abort (done still
//   pulses). Requester must drop req at the edge ending its done cycle or it re-requests.
//  Simultaneous requests: round-robin only, no fixed priority; a continuously requesting
//   channel waits at most 3 transactions.
//  Reads: rdata updated only on mem_ready of a read or write (write returns mem_rdata as-is).
//  mem_addr/mem_wdata are combinational from sel; all other outputs registered.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: counter runs in ACCESS; if mem_ready absent for TIMEOUT cycles,
//   -> DONE with done=grant, err=1, rdata=32'h0; counter cleared on ACCESS entry.
//  Undefined: no counter, ACCESS waits indefinitely, err tied 0.
// TESTING
//  1 Reset: RESETN=0 2 cycles, req=4'b1111 -> grant=0, mem_req=0, done=0, sel=0, rdata=0.
//  2 Single read: req=0010, addr1=0x100, mem_ready=1 w/ rdata 0xCAFEF00D in 1st ACCESS cycle
//    -> grant=0010, sel=1, mem_addr=0x100 at n+1; done=0010, rdata=0xCAFEF00D at n+2.
//  3 Fairness: req=1111 held, mem_ready=1 -> grant order 0001,0010,0100,1000,0001.
//  4 Wait states: req=0100 write wdata2=0x12345678, mem_ready after 5 cycles -> mem_req high
//    5 cycles, mem_we=1, mem_wdata=0x12345678, sel stable=2, single done=0100.
//  5 Reset mid-ACCESS: RESETN=0 during ACCESS -> next cycle IDLE, grant=0, no done pulse.
//  6 ARB_TIMEOUT_EN, TIMEOUT=16, mem_ready never -> after 16 ACCESS cycles done=owner,
//    err=1, rdata=0; without macro -> mem_req stays high, err=0.

Source files
------------

// File: rtl/mem_port_arbiter_4ch.sv
// mem_port_arbiter_4ch: round-robin sequencer sharing one memory port among four requesters.
// Optional ACCESS timeout/abort enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter_4ch #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [3:0]      req,
  input  logic [3:0]      req_we,
  input  logic [4*AW-1:0] req_addr,
  input  logic [127:0]    req_wdata,
  output logic [3:0]      grant,
  output logic [3:0]      done,
  output logic [31:0]     rdata,
  output logic [1:0]      sel,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic            mem_ready,
  input  logic [31:0]     mem_rdata,
  output logic            busy,
  output logic            err
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t      state, state_n;
  logic [1:0]  last, last_n, sel_n, win;
  logic [3:0]  grant_n, done_n;
  logic [31:0] rdata_n;
  logic        mem_req_n, mem_we_n, busy_n, err_n, to;
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt, cnt_n;
  assign to = (cnt == CW'(TIMEOUT - 1));
`else
  assign to = 1'b0;
`endif
  assign mem_addr  = req_addr[int'(sel)*AW +: AW];
  assign mem_wdata = req_wdata[int'(sel)*32 +: 32];
  // Scan downwards so the nearest set bit after last wins; k=4 wraps back to last itself.
  always_comb begin
    win = last;
    for (int k = 4; k >= 1; k--)
      if (req[last + 2'(k)]) win = last + 2'(k);
  end
  always_comb begin
    state_n   = state;
    last_n    = last;
    grant_n   = grant;
    sel_n     = sel;
    done_n    = '0;
    rdata_n   = rdata;
    mem_req_n = mem_req;
    mem_we_n  = mem_we;
    busy_n    = busy;
    err_n     = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_n     = cnt;
`endif
    case (state)
      IDLE: if (|req) begin
        state_n   = ACCESS;
        grant_n   = 4'b0001 << win;
        sel_n     = win;
        last_n    = win;
        mem_req_n = 1'b1;
        mem_we_n  = req_we[win];
        busy_n    = 1'b1;
`ifdef ARB_TIMEOUT_EN
        cnt_n     = '0;
`endif
      end
      ACCESS: if (mem_ready || to) begin
        state_n   = DONE;
        done_n    = grant;
        rdata_n   = mem_ready ? mem_rdata : '0;
        err_n     = !mem_ready;
        mem_req_n = 1'b0;
        mem_we_n  = 1'b0;
      end else begin
`ifdef ARB_TIMEOUT_EN
        cnt_n = cnt + 1'b1;
`endif
      end
      DONE: begin
        state_n = IDLE;
        grant_n = '0;
        busy_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      last    <= 2'd3;
      grant   <= '0;
      sel     <= '0;
      done    <= '0;
      rdata   <= '0;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      last    <= last_n;
      grant   <= grant_n;
      sel     <= sel_n;
      done    <= done_n;
      rdata   <= rdata_n;
      mem_req <= mem_req_n;
      mem_we  <= mem_we_n;
      busy    <= busy_n;
      err     <= err_n;
    end
  end
`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!resetn) cnt <= '0;
    else cnt <= cnt_n;
  end
`endif
endmodule
